// File: rtl/timer_sequencer.sv
// Control FSM for the BCD countdown timer: key debounce, switch clamping, 1 Hz tick,
// blink and alarm flash. Define ALARM_TIMEOUT_EN to auto-clear ALARM after ALARM_SECS ticks.
module timer_sequencer #(
  parameter int TICK_DIV     = 50000000,
  parameter int BLINK_DIV    = 20000000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int ALARM_SECS   = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_set_n,
  input  logic       key_run_n,
  input  logic [7:0] sw,
  input  logic       cnt_zero,
  output logic       ld_sec,
  output logic       ld_min,
  output logic [7:0] ld_val,
  output logic       dec_en,
  output logic       blank_sec,
  output logic       blank_min,
  output logic       alarm,
  output logic [2:0] state
);

  localparam logic [2:0] SET_SEC = 3'd0;
  localparam logic [2:0] SET_MIN = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] PAUSE   = 3'd3;
  localparam logic [2:0] ALARM   = 3'd4;

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int DEB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);

  // Key conditioning; bit 0 is SET, bit 1 is RUN.
  logic [1:0]       key_meta;
  logic [1:0]       key_sync;
  logic [1:0]       key_deb;
  logic [1:0]       key_press;
  logic [DEB_W-1:0] deb_cnt [2];

  logic set_p;
  logic run_p;

  logic [7:0] sw_meta;
  logic [7:0] sw_sync;

  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               alarm_phase;

  logic [2:0] state_next;
  logic       run_go;
  logic       alarm_expire;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_meta  <= 2'b11;
      key_sync  <= 2'b11;
      key_deb   <= 2'b11;
      key_press <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      key_meta  <= {key_run_n, key_set_n};
      key_sync  <= key_meta;
      key_press <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (key_sync[i] == key_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          // Level accepted; only the press (1->0) edge produces an event.
          deb_cnt[i]   <= '0;
          key_deb[i]   <= key_sync[i];
          key_press[i] <= ~key_sync[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign set_p = key_press[0];
  assign run_p = key_press[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // Minutes allow tens up to 9; every other state uses the seconds range.
  always_comb begin
    // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
    logic [3:0] tens;
    logic [3:0] ones;
    tens = sw_sync[7:4];
    ones = sw_sync[3:0];
    if (state == SET_MIN) begin
      if (tens > 4'd9) tens = 4'd9;
    end else begin
      if (tens > 4'd5) tens = 4'd5;
    end
    if (ones > 4'd9) ones = 4'd9;
    ld_val = {tens, ones};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank_sec = (state == SET_SEC) & blink_phase;
  assign blank_min = (state == SET_MIN) & blink_phase;

  assign tick   = (tick_cnt == TICK_LAST);
  assign run_go = run_p & ~cnt_zero;

`ifdef ALARM_TIMEOUT_EN
  localparam int ALM_W = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;
  localparam logic [ALM_W-1:0] ALARM_LAST = ALM_W'(ALARM_SECS - 1);

  logic [ALM_W-1:0] alarm_ticks;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_ticks <= '0;
    end else if (state != ALARM) begin
      alarm_ticks <= '0;
    end else if (tick) begin
      alarm_ticks <= alarm_ticks + 1'b1;
    end
  end

  assign alarm_expire = tick & (alarm_ticks == ALARM_LAST);
`else
  assign alarm_expire = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      SET_SEC: begin
        if (run_go)     state_next = RUN;
        else if (set_p) state_next = SET_MIN;
      end
      SET_MIN: begin
        if (run_go)     state_next = RUN;
        else if (set_p) state_next = SET_SEC;
      end
      RUN: begin
        if (run_p)                state_next = PAUSE;
        else if (tick & cnt_zero) state_next = ALARM;
      end
      PAUSE: begin
        if (run_p)      state_next = RUN;
        else if (set_p) state_next = SET_SEC;
      end
      ALARM: begin
        if (set_p | run_p | alarm_expire) state_next = SET_SEC;
      end
      default: state_next = SET_SEC;
    endcase
  end

  // Held at zero in the set states, so every entry to RUN from them starts a full second.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else begin
      case (state)
        RUN, ALARM: begin
          if (state == RUN && state_next == ALARM) tick_cnt <= '0;
          else if (tick)                           tick_cnt <= '0;
          else                                     tick_cnt <= tick_cnt + 1'b1;
        end
        PAUSE:   tick_cnt <= tick_cnt;
        default: tick_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_phase <= 1'b0;
    end else if (state == ALARM) begin
      if (state_next != ALARM) alarm_phase <= 1'b0;
      else if (tick)           alarm_phase <= ~alarm_phase;
    end else begin
      alarm_phase <= 1'b0;
    end
  end

  assign alarm = alarm_phase;

  // Strobes follow the next state, so ld_* line up with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= SET_SEC;
      ld_sec <= 1'b0;
      ld_min <= 1'b0;
      dec_en <= 1'b0;
    end else begin
      state  <= state_next;
      ld_sec <= (state_next == SET_SEC);
      ld_min <= (state_next == SET_MIN);
      dec_en <= (state == RUN) & tick & ~cnt_zero & ~run_p;
    end
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed self-checking bench for timer_sequencer with small divider values.
module tb_timer_sequencer;

  localparam int TICK_DIV     = 10;
  localparam int BLINK_DIV    = 4;
  localparam int DEBOUNCE_CYC = 3;
  localparam int ALARM_SECS   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_set_n = 1'b1;
  logic       key_run_n = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       cnt_zero = 1'b0;
  logic       ld_sec;
  logic       ld_min;
  logic [7:0] ld_val;
  logic       dec_en;
  logic       blank_sec;
  logic       blank_min;
  logic       alarm;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_sequencer #(
    .TICK_DIV    (TICK_DIV),
    .BLINK_DIV   (BLINK_DIV),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .ALARM_SECS  (ALARM_SECS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_set_n(key_set_n),
    .key_run_n(key_run_n),
    .sw       (sw),
    .cnt_zero (cnt_zero),
    .ld_sec   (ld_sec),
    .ld_min   (ld_min),
    .ld_val   (ld_val),
    .dec_en   (dec_en),
    .blank_sec(blank_sec),
    .blank_min(blank_min),
    .alarm    (alarm),
    .state    (state)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (state === s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    cyc(3);
    checks++;
    if ({ld_sec, ld_min, ld_val, dec_en, blank_sec, blank_min, alarm, state} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ld_sec=%b ld_min=%b ld_val=%h dec_en=%b blank=%b%b alarm=%b state=%0d, want all 0",
               ld_sec, ld_min, ld_val, dec_en, blank_sec, blank_min, alarm, state);
    end
    reset = 1'b1;
    cyc(1);
    checks++;
    if (state !== 3'd0 || ld_sec !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: state=%0d ld_sec=%b, want state=0 ld_sec=1", state, ld_sec);
    end
  endtask

  task automatic test_set_clamp;
    bit ok;
    int ones_cnt;
    sw = 8'hF7;
    cyc(1);
    checks++;
    if (ld_val !== 8'h00) begin
      errors++;
      $display("FAIL sw_latency1: ld_val=%h want 00", ld_val);
    end
    cyc(1);
    checks++;
    if (ld_val !== 8'h57 || ld_sec !== 1'b1) begin
      errors++;
      $display("FAIL clamp_sec_F7: ld_val=%h ld_sec=%b want 57/1", ld_val, ld_sec);
    end
    key_set_n = 1'b0;
    wait_state(3'd1, 20, ok);
    key_set_n = 1'b1;
    checks++;
    if (!ok || ld_min !== 1'b1 || ld_sec !== 1'b0 || ld_val !== 8'h97) begin
      errors++;
      $display("FAIL set_to_min: state=%0d ld_min=%b ld_sec=%b ld_val=%h want 1/1/0/97",
               state, ld_min, ld_sec, ld_val);
    end
    ones_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (blank_min === 1'b1) ones_cnt++;
      checks++;
      if (blank_sec !== 1'b0) begin
        errors++;
        $display("FAIL blank_sec_in_min: blank_sec=%b want 0", blank_sec);
      end
    end
    checks++;
    if (ones_cnt != 4) begin
      errors++;
      $display("FAIL blank_min_duty: %0d of 8 cycles blanked, want 4", ones_cnt);
    end
    sw = 8'hAC;
    cyc(2);
    checks++;
    if (ld_val !== 8'h99) begin
      errors++;
      $display("FAIL clamp_min_AC: ld_val=%h want 99", ld_val);
    end
    sw = 8'h6B;
    cyc(2);
    checks++;
    if (ld_val !== 8'h69) begin
      errors++;
      $display("FAIL clamp_min_6B: ld_val=%h want 69", ld_val);
    end
    key_set_n = 1'b0;
    wait_state(3'd0, 20, ok);
    key_set_n = 1'b1;
    checks++;
    if (!ok || ld_sec !== 1'b1 || ld_min !== 1'b0 || ld_val !== 8'h59) begin
      errors++;
      $display("FAIL min_to_sec: state=%0d ld_sec=%b ld_min=%b ld_val=%h want 0/1/0/59",
               state, ld_sec, ld_min, ld_val);
    end
    cyc(8);
  endtask

  task automatic test_blink;
    bit found;
    logic prev;
    found = 1'b0;
    prev  = blank_sec;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (prev === 1'b0 && blank_sec === 1'b1) begin
        found = 1'b1;
        break;
      end
      prev = blank_sec;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL blink_rise: no blank_sec rise within 12 cycles");
    end
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      checks++;
      if (blank_sec !== ((k < 4) || (k == 8)) || blank_min !== 1'b0) begin
        errors++;
        $display("FAIL blink_pattern[%0d]: blank_sec=%b blank_min=%b want %b/0",
                 k, blank_sec, blank_min, (k < 4) || (k == 8));
      end
    end
  endtask

  task automatic test_debounce;
    int trans;
    logic [2:0] prev;
    key_set_n = 1'b0;
    cyc(2);
    key_set_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      checks++;
      if (state !== 3'd0) begin
        errors++;
        $display("FAIL glitch_ignored[%0d]: state=%0d want 0", i, state);
      end
    end
    trans = 0;
    prev  = state;
    key_set_n = 1'b0;
    for (int i = 0; i < 36; i++) begin
      cyc(1);
      if (i == 5) key_set_n = 1'b1;
      if (state !== prev) trans++;
      prev = state;
    end
    checks++;
    if (trans != 1 || state !== 3'd1) begin
      errors++;
      $display("FAIL debounce_single: %0d transitions ending in state %0d, want 1 ending in 1",
               trans, state);
    end
  endtask

  task automatic test_run_tick;
    bit ok;
    cnt_zero  = 1'b0;
    key_run_n = 1'b0;
    wait_state(3'd2, 20, ok);
    key_run_n = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL run_entry: state=%0d want 2", state);
    end
    // SET is pressed mid-run and must be ignored.
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (i == 2)  key_set_n = 1'b0;
      if (i == 10) key_set_n = 1'b1;
      checks++;
      if (dec_en !== ((i == 10) || (i == 20)) || state !== 3'd2) begin
        errors++;
        $display("FAIL run_tick[%0d]: dec_en=%b state=%0d want %b/2",
                 i, dec_en, state, (i == 10) || (i == 20));
      end
    end
  endtask

  task automatic test_pause;
    bit ok;
    int v;
    int exp_lat;
    int first;
    for (int i = 1; i <= 9; i++) begin
      cyc(1);
      checks++;
      if (dec_en !== 1'b0) begin
        errors++;
        $display("FAIL run_gap[%0d]: dec_en=%b want 0", i, dec_en);
      end
    end
    // Bench-side second counter: value seen in each sampled RUN cycle.
    v  = TICK_DIV - 1;
    ok = 1'b0;
    key_run_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (state === 3'd3) begin
        ok = 1'b1;
        break;
      end
      v = (v + 1) % TICK_DIV;
    end
    key_run_n = 1'b1;
    checks++;
    if (!ok || v == TICK_DIV - 1) begin
      errors++;
      $display("FAIL pause_entry: state=%0d count=%0d want state 3 before a tick", state, v);
    end
    exp_lat = TICK_DIV - 1 - v;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      checks++;
      if (dec_en !== 1'b0 || state !== 3'd3) begin
        errors++;
        $display("FAIL pause_hold[%0d]: dec_en=%b state=%0d want 0/3", i, dec_en, state);
      end
    end
    key_run_n = 1'b0;
    wait_state(3'd2, 20, ok);
    key_run_n = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL resume_entry: state=%0d want 2", state);
    end
    first = 0;
    for (int j = 1; j <= 12; j++) begin
      cyc(1);
      if (dec_en === 1'b1) begin
        first = j;
        break;
      end
    end
    checks++;
    if (first != exp_lat) begin
      errors++;
      $display("FAIL resume_latency: dec_en after %0d cycles, want %0d", first, exp_lat);
    end
  endtask

  task automatic test_alarm;
    bit ok;
    cnt_zero = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      cyc(1);
      checks++;
      if (dec_en !== 1'b0 || state !== ((j == 10) ? 3'd4 : 3'd2)) begin
        errors++;
        $display("FAIL alarm_entry[%0d]: dec_en=%b state=%0d want 0/%0d",
                 j, dec_en, state, (j == 10) ? 4 : 2);
      end
    end
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL alarm_initial: alarm=%b want 0", alarm);
    end
`ifdef ALARM_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      checks++;
      if (state !== ((k == 20) ? 3'd0 : 3'd4) || alarm !== ((k >= 10) && (k < 20))) begin
        errors++;
        $display("FAIL alarm_timeout[%0d]: state=%0d alarm=%b want %0d/%b",
                 k, state, alarm, (k == 20) ? 0 : 4, (k >= 10) && (k < 20));
      end
    end
    cnt_zero  = 1'b0;
    key_run_n = 1'b0;
    wait_state(3'd2, 20, ok);
    key_run_n = 1'b1;
    cnt_zero  = 1'b1;
    wait_state(3'd4, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL alarm_reenter: state=%0d want 4", state);
    end
`else
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      checks++;
      if (state !== 3'd4 || alarm !== (((k / 10) % 2) == 1)) begin
        errors++;
        $display("FAIL alarm_flash[%0d]: state=%0d alarm=%b want 4/%b",
                 k, state, alarm, ((k / 10) % 2) == 1);
      end
    end
`endif
    key_set_n = 1'b0;
    wait_state(3'd0, 20, ok);
    key_set_n = 1'b1;
    checks++;
    if (!ok || alarm !== 1'b0 || ld_sec !== 1'b1) begin
      errors++;
      $display("FAIL alarm_exit: state=%0d alarm=%b ld_sec=%b want 0/0/1", state, alarm, ld_sec);
    end
    cyc(8);
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    cnt_zero  = 1'b0;
    sw        = 8'h12;
    key_run_n = 1'b0;
    wait_state(3'd2, 20, ok);
    key_run_n = 1'b1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_run_entry: state=%0d want 2", state);
    end
    cyc(3);
    reset = 1'b0;
    #1;
    checks++;
    if ({ld_sec, ld_min, ld_val, dec_en, blank_sec, blank_min, alarm, state} !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: ld_sec=%b ld_min=%b ld_val=%h dec_en=%b blank=%b%b alarm=%b state=%0d, want all 0",
               ld_sec, ld_min, ld_val, dec_en, blank_sec, blank_min, alarm, state);
    end
    cyc(2);
    reset    = 1'b1;
    sw       = 8'h00;
    cnt_zero = 1'b1;
    cyc(3);
    key_run_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (i == 8) key_run_n = 1'b1;
      checks++;
      if (state !== 3'd0) begin
        errors++;
        $display("FAIL run_zero_ignored[%0d]: state=%0d want 0", i, state);
      end
    end
    checks++;
    if (ld_sec !== 1'b1 || ld_val !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_load: ld_sec=%b ld_val=%h want 1/00", ld_sec, ld_val);
    end
  endtask

  initial begin
    test_reset();
    test_set_clamp();
    test_blink();
    test_debounce();
    test_run_tick();
    test_pause();
    test_alarm();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
